sevenseg_scan_ctrl: RTL

Parametrised multiplexed seven-segment display driver for board-level debug output. It time-multiplexes NUM_DIGITS hex digits onto one shared segment bus plus per-digit anode enables. Compared with a fixed 8-digit scanner it adds:
- generic digit count and refresh divider
- frame-coherent data snapshot, so no tearing
- per-digit decimal point
- leading-zero blanking
- run/hold enable
- selectable output polarity
It sits in the top level between the core's debug_output bus and the board pins.

---
 rtl/sevenseg_scan_ctrl_if.sv | 25 ++
 rtl/sevenseg_scan_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl_if.sv
// Display bundle between the debug source and the seven-segment scanner.
// The master drives the digit data; the slave (scanner) drives the board pins.
interface sevenseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
);
    logic                    en;
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              sev_out;
    logic                    dp_out;
    logic [IDX_W-1:0]        digit_idx;

    modport master (
        output en, data, dp_in, blank_lz,
        input  an, sev_out, dp_out, digit_idx
    );

    modport slave (
        input  en, data, dp_in, blank_lz,
        output an, sev_out, dp_out, digit_idx
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed hex seven-segment scanner with frame snapshot,
// leading-zero blanking, run/hold and selectable pin polarity.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int DIV_COUNT      = 500,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int IDX_W          = $clog2(NUM_DIGITS)
) (
    input logic                 clk,
    input logic                 Rst,
    sevenseg_scan_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DIV_COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                    load_pend_q, load_pend_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [IDX_W-1:0]        didx_q, didx_d;

    logic                    tick;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [3:0]              nib;
    logic                    show;
    logic [6:0]              lit;
    logic [NUM_DIGITS-1:0]   an_raw;
    logic                    dp_raw;

    function automatic logic [6:0] hex_low(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Divider, scan index and frame snapshot
    always_comb begin
        tick = bus.en && (cnt_q == CNT_LAST);
        load = bus.en &&
               (load_pend_q || (tick && (idx_q == IDX_LAST)));
        cnt_d = cnt_q;
        if (bus.en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        snap_d      = load ? bus.data : snap_q;
        snap_dp_d   = load ? bus.dp_in : snap_dp_q;
        load_pend_d = load_pend_q && !bus.en;
    end

    // A digit is blank when it and every digit to its left are zero
    always_comb begin : lz_blk
        logic zero_run;
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (snap_q[4*i +: 4] == 4'h0);
            blank_vec[i] = bus.blank_lz && (i != 0) && zero_run;
        end
    end

    always_comb begin
        nib    = snap_q[{idx_q, 2'b00} +: 4];
        show   = bus.en && !blank_vec[idx_q];
        lit    = show ? ~hex_low(nib) : 7'b0000000;
        an_raw = '0;
        if (show) begin
            an_raw[idx_q] = 1'b1;
        end
        dp_raw = show && snap_dp_q[idx_q];
        an_d   = AN_ACTIVE_LOW ? ~an_raw : an_raw;
        seg_d  = SEG_ACTIVE_LOW ? ~lit : lit;
        dp_d   = SEG_ACTIVE_LOW ? ~dp_raw : dp_raw;
        didx_d = idx_q;
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            snap_q      <= '0;
            snap_dp_q   <= '0;
            load_pend_q <= 1'b1;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= SEG_ACTIVE_LOW;
            didx_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            snap_dp_q   <= snap_dp_d;
            load_pend_q <= load_pend_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            didx_q      <= didx_d;
        end
    end

    assign bus.an        = an_q;
    assign bus.sev_out   = seg_q;
    assign bus.dp_out    = dp_q;
    assign bus.digit_idx = didx_q;

endmodule
